// File: rtl/quat_collector.sv
`default_nettype none
// ============================================================================
//  Module   : quat_collector
//  Purpose  : Serial-to-parallel front end for the quaternion Hadamard stage.
//             Collects a0..a3 from a valid/ready beat stream, checks framing,
//             and presents the quaternion in parallel under valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module quat_collector #(
  parameter int DATA_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a0,
  output logic [DATA_W-1:0] out_a1,
  output logic [DATA_W-1:0] out_a2,
  output logic [DATA_W-1:0] out_a3,
  output logic              frame_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [1:0] C_LAST_IDX = 2'd3;

  // Collect register (slot per component) and output register.
  logic [DATA_W-1:0] col_q [4];
  logic [DATA_W-1:0] col_d [4];
  logic [DATA_W-1:0] out_q [4];
  logic [DATA_W-1:0] out_d [4];
  logic [1:0]        idx_q, idx_d;
  logic              collect_full_q, collect_full_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  // Holds in_ready low through reset and the first edge after release.
  logic              started_q, started_d;

  logic w_accept;
  logic w_good_last;
  logic w_bad_beat;
  logic w_out_free;
  logic w_move;

  // Beat classification and transfer decisions.
  always_comb begin
    w_accept    = in_valid & in_ready;
    w_good_last = w_accept & in_last & (idx_q == C_LAST_IDX);
    w_bad_beat  = w_accept & (in_last ^ (idx_q == C_LAST_IDX));
    w_out_free  = ~out_valid_q | out_ready;
    // The collect register can only be full while input is stalled, so
    // a good last beat and collect_full never coincide.
    w_move      = (collect_full_q | w_good_last) & w_out_free;
  end

  // Next-state computation for collect/output registers and error tracking.
  always_comb begin
    col_d          = col_q;
    out_d          = out_q;
    idx_d          = idx_q;
    collect_full_d = collect_full_q;
    out_valid_d    = out_valid_q;
    frame_err_d    = 1'b0;
    err_count_d    = err_count_q;
    started_d      = 1'b1;

    if (w_accept) begin
      col_d[idx_q] = in_data;
      if (w_good_last || w_bad_beat) begin
        idx_d = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    if (w_bad_beat) begin
      frame_err_d = 1'b1;
      if (err_count_q != {ERR_W{1'b1}}) begin
        err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end
    end

    if (w_move) begin
      out_valid_d = 1'b1;
      if (collect_full_q) begin
        out_d          = col_q;
        collect_full_d = 1'b0;
      end else begin
        // Fast path: the a3 beat bypasses the collect register.
        out_d[0] = col_q[0];
        out_d[1] = col_q[1];
        out_d[2] = col_q[2];
        out_d[3] = in_data;
      end
    end else begin
      if (w_good_last) begin
        collect_full_d = 1'b1;
      end
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        col_q[i] <= '0;
        out_q[i] <= '0;
      end
      idx_q          <= 2'd0;
      collect_full_q <= 1'b0;
      out_valid_q    <= 1'b0;
      frame_err_q    <= 1'b0;
      err_count_q    <= '0;
      started_q      <= 1'b0;
    end else begin
      col_q          <= col_d;
      out_q          <= out_d;
      idx_q          <= idx_d;
      collect_full_q <= collect_full_d;
      out_valid_q    <= out_valid_d;
      frame_err_q    <= frame_err_d;
      err_count_q    <= err_count_d;
      started_q      <= started_d;
    end
  end

  // Output mapping.
  always_comb begin
    in_ready  = started_q & ~collect_full_q;
    out_valid = out_valid_q;
    out_a0    = out_q[0];
    out_a1    = out_q[1];
    out_a2    = out_q[2];
    out_a3    = out_q[3];
    frame_err = frame_err_q;
    err_count = err_count_q;
  end

endmodule
`default_nettype wire
